// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default widths for the fetch controller
package fetch_pkg;

    localparam int FETCH_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADDR  = 3'd2,
        INC   = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - memory wait-cycle counter with terminal-count flag
module fetch_wait_timer #(
    parameter int TERMINAL = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int WIDTH = $clog2(TERMINAL + 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Flags the wait cycle whose increment makes the count reach TERMINAL.
    assign o_terminal = (r_count == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC/memory fetch sequencer; FETCH_TIMEOUT_EN adds a wait timeout to FAULT
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH     = FETCH_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  jump,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] data_bus,
    output logic                  pc_notLoad,
    output logic                  pc_inc,
    output logic                  pc_notOE,
    output logic                  mem_notRead,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    output logic                  busy,
    output logic                  fault
);

    fetch_state_t          r_state;
    fetch_state_t          w_next;
    logic [DATA_WIDTH-1:0] r_ir;
    logic                  w_timeout;

`ifdef FETCH_TIMEOUT_EN
    fetch_wait_timer #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (r_state != ADDR),
        .i_enable   ((r_state == ADDR) && !mem_ready),
        .o_terminal (w_timeout)
    );
    assign fault = (r_state == FAULT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
    assign fault            = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir <= '0;
        end else if ((r_state == ADDR) && mem_ready) begin
            r_ir <= data_bus;
        end
    end

    always_comb begin
        w_next      = r_state;
        pc_notLoad  = 1'b1;
        pc_inc      = 1'b0;
        pc_notOE    = 1'b1;
        mem_notRead = 1'b1;
        ir_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (jump) begin
                    w_next = LOAD;
                end else if (start) begin
                    w_next = ADDR;
                end
            end
            LOAD: begin
                pc_notLoad = 1'b0;
                w_next     = IDLE;
            end
            ADDR: begin
                pc_notOE    = 1'b0;
                mem_notRead = 1'b0;
                // A late mem_ready on the terminal wait cycle still completes the fetch.
                if (mem_ready) begin
                    w_next = INC;
                end else if (w_timeout) begin
                    w_next = FAULT;
                end
            end
            INC: begin
                pc_inc   = 1'b1;
                ir_valid = 1'b1;
                w_next   = IDLE;
            end
            FAULT: begin
                w_next = FAULT;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign ir   = r_ir;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - table-driven self-checking bench for fetch_controller
module tb_fetch_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        jump;
    logic        mem_ready;
    logic [15:0] data_bus;
    logic        pc_notLoad;
    logic        pc_inc;
    logic        pc_notOE;
    logic        mem_notRead;
    logic [15:0] ir;
    logic        ir_valid;
    logic        busy;
    logic        fault;

    int checks = 0;
    int errors = 0;

    fetch_controller #(
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .jump        (jump),
        .mem_ready   (mem_ready),
        .data_bus    (data_bus),
        .pc_notLoad  (pc_notLoad),
        .pc_inc      (pc_inc),
        .pc_notOE    (pc_notOE),
        .mem_notRead (mem_notRead),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic        st;
        logic        jp;
        logic        mr;
        logic [15:0] din;
        logic        e_nload;
        logic        e_inc;
        logic        e_noe;
        logic        e_nrd;
        logic [15:0] e_ir;
        logic        e_valid;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic jp, input logic mr, input logic [15:0] din,
                       input logic nl, input logic inc, input logic noe, input logic nrd,
                       input logic [15:0] eir, input logic v, input logic b);
        vec_t v_rec;
        v_rec = '{rst, st, jp, mr, din, nl, inc, noe, nrd, eir, v, b};
        vecs.push_back(v_rec);
    endtask

    task automatic step(input logic rst, input logic st, input logic jp, input logic mr, input logic [15:0] din);
        reset = rst; start = st; jump = jp; mem_ready = mr; data_bus = din;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; jump = 1'b0; mem_ready = 1'b0; data_bus = 16'h0;

        //  rst st jp mr data      nLd inc nOE nRd ir        vld busy
        add(1, 0, 0, 0, 16'h0000, 1,  0,  1,  1,  16'h0000, 0,  0);  // reset -> IDLE
        add(0, 1, 0, 1, 16'hA5C3, 1,  0,  0,  0,  16'h0000, 0,  1);  // start -> ADDR
        add(0, 0, 0, 1, 16'hA5C3, 1,  1,  1,  1,  16'hA5C3, 1,  1);  // zero wait -> INC
        add(0, 0, 0, 0, 16'h0000, 1,  0,  1,  1,  16'hA5C3, 0,  0);  // IDLE
        add(0, 1, 0, 0, 16'h1234, 1,  0,  0,  0,  16'hA5C3, 0,  1);  // ADDR 1
        add(0, 0, 0, 0, 16'h1234, 1,  0,  0,  0,  16'hA5C3, 0,  1);  // ADDR 2
        add(0, 0, 0, 0, 16'h1234, 1,  0,  0,  0,  16'hA5C3, 0,  1);  // ADDR 3
        add(0, 0, 0, 0, 16'h1234, 1,  0,  0,  0,  16'hA5C3, 0,  1);  // ADDR 4
        add(0, 0, 0, 0, 16'h1234, 1,  0,  0,  0,  16'hA5C3, 0,  1);  // ADDR 5
        add(0, 0, 0, 1, 16'h1234, 1,  1,  1,  1,  16'h1234, 1,  1);  // INC
        add(0, 0, 0, 0, 16'h0000, 1,  0,  1,  1,  16'h1234, 0,  0);  // IDLE
        add(0, 1, 1, 0, 16'h0000, 0,  0,  1,  1,  16'h1234, 0,  1);  // jump wins -> LOAD
        add(0, 1, 0, 0, 16'h0000, 1,  0,  1,  1,  16'h1234, 0,  0);  // LOAD -> IDLE, start ignored
        add(0, 1, 0, 1, 16'h0F0F, 1,  0,  0,  0,  16'h1234, 0,  1);  // start re-sampled -> ADDR
        add(0, 0, 0, 1, 16'h0F0F, 1,  1,  1,  1,  16'h0F0F, 1,  1);  // INC
        add(0, 0, 0, 0, 16'h0000, 1,  0,  1,  1,  16'h0F0F, 0,  0);  // IDLE
        add(0, 1, 0, 0, 16'hFFFF, 1,  0,  0,  0,  16'h0F0F, 0,  1);  // ADDR
        add(0, 0, 0, 0, 16'hFFFF, 1,  0,  0,  0,  16'h0F0F, 0,  1);  // ADDR waiting
        add(1, 0, 0, 0, 16'hFFFF, 1,  0,  1,  1,  16'h0000, 0,  0);  // reset mid-ADDR
        add(0, 0, 1, 0, 16'h0000, 0,  0,  1,  1,  16'h0000, 0,  1);  // jump -> LOAD
        add(0, 0, 0, 0, 16'h0000, 1,  0,  1,  1,  16'h0000, 0,  0);  // IDLE
        add(0, 1, 0, 1, 16'hBEEF, 1,  0,  0,  0,  16'h0000, 0,  1);  // back-to-back: ADDR
        add(0, 1, 0, 1, 16'hBEEF, 1,  1,  1,  1,  16'hBEEF, 1,  1);  // INC
        add(0, 1, 0, 1, 16'h0001, 1,  0,  1,  1,  16'hBEEF, 0,  0);  // IDLE
        add(0, 1, 0, 1, 16'h0001, 1,  0,  0,  0,  16'hBEEF, 0,  1);  // ADDR (period 3)
        add(0, 0, 0, 1, 16'h0001, 1,  1,  1,  1,  16'h0001, 1,  1);  // INC
        add(0, 0, 0, 0, 16'h0000, 1,  0,  1,  1,  16'h0001, 0,  0);  // IDLE

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].jp, vecs[i].mr, vecs[i].din);
            check("pc_notLoad",  i, 16'(pc_notLoad),  16'(vecs[i].e_nload));
            check("pc_inc",      i, 16'(pc_inc),      16'(vecs[i].e_inc));
            check("pc_notOE",    i, 16'(pc_notOE),    16'(vecs[i].e_noe));
            check("mem_notRead", i, 16'(mem_notRead), 16'(vecs[i].e_nrd));
            check("ir",          i, ir,               vecs[i].e_ir);
            check("ir_valid",    i, 16'(ir_valid),    16'(vecs[i].e_valid));
            check("busy",        i, 16'(busy),        16'(vecs[i].e_busy));
            check("fault",       i, 16'(fault),       16'h0);
            check("load_inc_excl", i, 16'(!pc_notLoad && pc_inc), 16'h0);
        end

        // Long stall: ADDR forever by default, FAULT after 15 ADDR cycles with the timeout.
        step(1, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h5555);
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 0, 0, 16'h5555);
`ifdef FETCH_TIMEOUT_EN
            check("stall_fault",  100 + k, 16'(fault),       16'(k >= 15));
            check("stall_notOE",  100 + k, 16'(pc_notOE),    16'(k >= 15));
            check("stall_notRd",  100 + k, 16'(mem_notRead), 16'(k >= 15));
`else
            check("stall_fault",  100 + k, 16'(fault),       16'h0);
            check("stall_notOE",  100 + k, 16'(pc_notOE),    16'h0);
            check("stall_notRd",  100 + k, 16'(mem_notRead), 16'h0);
`endif
            check("stall_busy",   100 + k, 16'(busy),        16'h1);
            check("stall_inc",    100 + k, 16'(pc_inc),      16'h0);
        end
        step(0, 1, 1, 1, 16'h7777);
`ifdef FETCH_TIMEOUT_EN
        check("fault_sticky", 200, 16'(fault), 16'h1);
        check("fault_nload",  200, 16'(pc_notLoad), 16'h1);
`else
        check("late_ready_inc", 200, 16'(pc_inc), 16'h1);
        check("late_ready_ir",  200, ir, 16'h7777);
`endif
        step(1, 0, 0, 0, 16'h0);
        check("post_reset_fault", 201, 16'(fault), 16'h0);
        check("post_reset_busy",  201, 16'(busy),  16'h0);
        check("post_reset_ir",    201, ir,         16'h0000);

        // mem_ready arrives on the 15th ADDR cycle: fetch must complete in both builds.
        step(0, 1, 0, 0, 16'h0);
        for (int k = 1; k <= 14; k++) begin
            step(0, 0, 0, 0, 16'h0);
            check("edge_wait_busy", 300 + k, 16'(pc_notOE), 16'h0);
        end
        step(0, 0, 0, 1, 16'hC0DE);
        check("edge_inc",   320, 16'(pc_inc),   16'h1);
        check("edge_ir",    320, ir,            16'hC0DE);
        check("edge_fault", 320, 16'(fault),    16'h0);
        step(0, 0, 0, 0, 16'h0);
        check("edge_idle",  321, 16'(busy),     16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Control-side partner of the program counter: sequences instruction fetches by driving the PC's active-low load, increment and output-enable strobes plus the memory read strobe, then captures the returned word into an instruction register. Sits between the control unit (start/jump requests) and the PC/memory/address-data buses. It is the consumer and driver of the PC control interface.

## Interface
Parameters:
- DATA_WIDTH, 16, width of data bus and instruction register
- TIMEOUT_CYCLES, 15, max ADDR-state wait cycles before fault (used only with FETCH_TIMEOUT_EN)

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request one fetch; sampled only in IDLE
- jump  in  1  request PC load from datapath-supplied address; sampled only in IDLE; priority over start
- mem_ready  in  1  memory has valid data on data_bus this cycle
- data_bus  in  DATA_WIDTH  memory read data
- pc_notLoad  out  1  active-low PC synchronous load
- pc_inc  out  1  PC count enable
- pc_notOE  out  1  active-low PC address-bus output enable
- mem_notRead  out  1  active-low memory read strobe
- ir  out  DATA_WIDTH  instruction register
- ir_valid  out  1  one-cycle pulse: ir updated
- busy  out  1  1 whenever state != IDLE
- fault  out  1  sticky timeout flag (constant 0 without FETCH_TIMEOUT_EN)

## Operation
- States: IDLE, LOAD, ADDR, INC, FAULT.
- IDLE: all strobes inactive (pc_notLoad=1, pc_inc=0, pc_notOE=1, mem_notRead=1). jump=1 -> LOAD; else start=1 -> ADDR; else stay.
- LOAD: pc_notLoad=0 for exactly one cycle -> IDLE. start during LOAD ignored; caller holds it.
- ADDR: pc_notOE=0, mem_notRead=0. mem_ready=1 at an edge -> ir <= data_bus, go INC. Otherwise stay.
- INC: pc_inc=1, ir_valid=1, strobes otherwise inactive, one cycle -> IDLE.
- pc_notLoad=0 and pc_inc=1 never simultaneous; pc_notOE=0 only in ADDR.
- FAULT: all strobes inactive, fault=1, busy=1; exit only by reset.
- Outputs are Moore (decoded from state register only); ir is a register.

## Timing
- Reset (any state, mid-fetch included): next edge -> IDLE, ir=0, ir_valid=0, fault=0, all strobes inactive, wait counter 0.
- Fetch with zero wait: start high at edge N -> ADDR during cycle N+1; mem_ready high in N+1 -> INC in N+2 (ir valid, ir_valid=1, PC counts at end of N+2) -> IDLE in N+3. Back-to-back fetch period = 3 cycles.
- Each extra wait cycle (mem_ready=0 in ADDR) adds one cycle.
- Jump: 2 cycles (LOAD, then IDLE).
- start and jump together in IDLE: LOAD only; start re-sampled in next IDLE.
- PC wrap 0xFFFF -> 0x0000 is PC behaviour; controller unaffected.

## Configuration
- FETCH_TIMEOUT_EN defined: wait counter (width clog2(TIMEOUT_CYCLES+1)) cleared on ADDR entry, increments each ADDR cycle with mem_ready=0; when count reaches TIMEOUT_CYCLES with mem_ready=0 -> FAULT. mem_ready=1 on that same cycle wins (-> INC).
- Not defined: ADDR waits indefinitely; FAULT unreachable; fault tied 0; no counter logic.

## Structure
- Shared package fetch_pkg: state enum (IDLE, LOAD, ADDR, INC, FAULT), FETCH_DATA_WIDTH=16 default constant.
- One sub-module: fetch_wait_timer (clear, enable, terminal-count output), instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- Reset mid-ADDR with mem_ready=0 -> next cycle IDLE, ir=0x0000, pc_notOE=1, mem_notRead=1, busy=0.
- start pulse, mem_ready=1 immediately, data_bus=0xA5C3 -> ADDR 1 cycle, INC 1 cycle with pc_inc=1, ir=0xA5C3, ir_valid single pulse.
- start, mem_ready delayed 4 cycles, data_bus=0x1234 -> pc_notOE/mem_notRead low exactly 5 cycles, ir=0x1234.
- jump and start both high in IDLE -> pc_notLoad low one cycle, pc_inc never high, then fetch begins after re-sampling start.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, mem_ready held 0 -> FAULT after 15 ADDR cycles, fault=1 sticky, strobes inactive until reset.
- FETCH_TIMEOUT_EN, mem_ready=1 on 15th wait cycle -> INC, fault stays 0.
